// File: rtl/branch_cmp_arbiter_if.sv
// Bundles the request, comparator and response signals of branch_cmp_arbiter.
// Ports: req_valid/req_ready plus per-requester operands, the cmp_* comparator link,
//        rsp_* one-deep response handshake and the taken_cnt monitor output.
interface branch_cmp_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [XLEN-1:0]  req0_a;
  logic [XLEN-1:0]  req0_b;
  logic [2:0]       req0_sel;
  logic [XLEN-1:0]  req1_a;
  logic [XLEN-1:0]  req1_b;
  logic [2:0]       req1_sel;
  logic [XLEN-1:0]  cmp_a;
  logic [XLEN-1:0]  cmp_b;
  logic [2:0]       cmp_sel;
  logic             cmp_taken;
  logic             rsp_valid;
  logic             rsp_id;
  logic             rsp_taken;
  logic             rsp_ready;
  logic [CNT_W-1:0] taken_cnt;

  // Requesters, comparator and response consumer collectively.
  modport master (
    output req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel,
    output cmp_taken, rsp_ready,
    input  req_ready, cmp_a, cmp_b, cmp_sel, rsp_valid, rsp_id, rsp_taken, taken_cnt
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel,
    input  cmp_taken, rsp_ready,
    output req_ready, cmp_a, cmp_b, cmp_sel, rsp_valid, rsp_id, rsp_taken, taken_cnt
  );
endinterface

// File: rtl/branch_cmp_arbiter.sv
// Round-robin share of one branch comparator between two requesters.
// Latency: result on rsp_* one cycle after the req_valid & req_ready handshake.
// Backpressure: a held response with rsp_ready low blocks all grants (req_ready = 0).
// Ports: clk, rst_n (async active-low) and the slave side of branch_cmp_arbiter_if,
//        carrying requests, the comparator link, the response slot and taken_cnt.
module branch_cmp_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_cmp_arbiter_if.slave    bus
);

  logic slot_free;
  logic gnt_vld;
  logic winner;
  logic rr_last;

  // The slot can take a new result if empty or being drained this cycle.
  assign slot_free = !bus.rsp_valid || bus.rsp_ready;

  always_comb begin
    gnt_vld = 1'b0;
    winner  = 1'b0;
    if (slot_free) begin
      case (bus.req_valid)
        2'b01: begin
          gnt_vld = 1'b1;
          winner  = 1'b0;
        end
        2'b10: begin
          gnt_vld = 1'b1;
          winner  = 1'b1;
        end
        2'b11: begin
          // Contention: whoever was not served last goes next.
          gnt_vld = 1'b1;
          winner  = ~rr_last;
        end
        default: begin
          gnt_vld = 1'b0;
          winner  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.req_ready = 2'b00;
    bus.cmp_a     = {XLEN{1'b0}};
    bus.cmp_b     = {XLEN{1'b0}};
    bus.cmp_sel   = 3'b111;  // idle encoding, comparator output ignored
    if (gnt_vld) begin
      bus.req_ready = winner ? 2'b10 : 2'b01;
      bus.cmp_a     = winner ? bus.req1_a   : bus.req0_a;
      bus.cmp_b     = winner ? bus.req1_b   : bus.req0_b;
      bus.cmp_sel   = winner ? bus.req1_sel : bus.req0_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_taken <= 1'b0;
      bus.taken_cnt <= '0;
      rr_last       <= 1'b1;  // requester 0 wins the first contention
    end else if (gnt_vld) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_id    <= winner;
      bus.rsp_taken <= bus.cmp_taken;
      rr_last       <= winner;
      if (bus.cmp_taken) begin
        bus.taken_cnt <= bus.taken_cnt + CNT_W'(1);
      end
    end else if (bus.rsp_ready) begin
      // Drain without refill; id/taken keep their last values.
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule
